// File: rtl/soc_io_pkg.sv
// soc_io_pkg
// Shared definitions for the IO-page UART/LED peripheral:
//   - byte offsets of the three registers in the IO page
//   - bit positions inside the STATUS word
//   - state encoding of the UART transmit FSM
package soc_io_pkg;

   localparam int unsigned REG_LED    = 32'h0;
   localparam int unsigned REG_TXDATA = 32'h4;
   localparam int unsigned REG_STATUS = 32'h8;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_LEVEL_MSB = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo
// Single-clock circular FIFO with occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (control only)
//   push, wdata   write request and data
//   pop           read request (ignored when empty)
//   rdata         head entry (combinational, valid when !empty)
//   full, empty   occupancy flags
//   level         number of stored entries, 0..DEPTH
module io_sync_fifo
   import soc_io_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // The slot freed by a simultaneous pop makes room for the push.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/soc_io_uart.sv
// soc_io_uart
// IO-space peripheral: LED output register plus a FIFO-buffered 8N1 UART
// transmitter behind a word-addressed register page.
//   0x0 LED     RW  bits[N_LEDS-1:0]
//   0x4 TXDATA  W   push wdata[7:0] into TX FIFO; reads 0
//   0x8 STATUS  R   [0] full [1] empty [2] busy [3] overflow [15:8] level
//               W   writing 1 to bit 3 clears overflow
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   IO_addr             byte offset of access (bits[1:0] ignored)
//   IO_wdata, IO_wen    write data and strobe
//   IO_ren              read strobe
//   IO_rdata            registered read data, valid the cycle after IO_ren
//   LEDS                LED register
//   TXD                 UART serial output, idle high, driven from a flop
module soc_io_uart
   import soc_io_pkg::*;
#(
   parameter int N_LEDS     = 5,
   parameter int FIFO_DEPTH = 16,
   parameter int BAUD_DIV   = 104,
   parameter int ADDR_W     = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] IO_addr,
   input  logic [31:0]       IO_wdata,
   input  logic              IO_wen,
   input  logic              IO_ren,
   output logic [31:0]       IO_rdata,
   output logic [N_LEDS-1:0] LEDS,
   output logic              TXD
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

   if (BAUD_DIV < 2) begin : g_chk_baud
      $error("soc_io_uart: BAUD_DIV must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("soc_io_uart: FIFO_DEPTH must be a power of two >= 2");
   end
   if (ADDR_W < 4) begin : g_chk_addr
      $error("soc_io_uart: ADDR_W must be >= 4 to reach STATUS");
   end

   // Address decode
   logic [ADDR_W-1:0] word_addr;
   logic              sel_led;
   logic              sel_txdata;
   logic              sel_status;
   logic              led_we;
   logic              tx_push;
   logic              ovf_clr;
   logic              ovf_set;

   assign word_addr  = {IO_addr[ADDR_W-1:2], 2'b00};
   assign sel_led    = (word_addr == ADDR_W'(REG_LED));
   assign sel_txdata = (word_addr == ADDR_W'(REG_TXDATA));
   assign sel_status = (word_addr == ADDR_W'(REG_STATUS));
   assign led_we     = IO_wen && sel_led;
   assign tx_push    = IO_wen && sel_txdata;
   assign ovf_clr    = IO_wen && sel_status && IO_wdata[ST_OVERFLOW];

   // Byte-lane address bits and data bits beyond the registers carry no meaning.
   logic unused_bits;
   assign unused_bits = ^{IO_wdata, IO_addr[1:0]};

   // TX FIFO
   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [LVL_W-1:0] fifo_level;

   io_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .push  (tx_push),
      .wdata (IO_wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // A push into a full FIFO is only dropped if no pop frees a slot that cycle.
   assign ovf_set = tx_push && fifo_full && !fifo_pop;

   // Register stage: LED, overflow flag
   logic overflow;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         LEDS     <= '0;
         overflow <= 1'b0;
      end else begin
         if (led_we) LEDS <= IO_wdata[N_LEDS-1:0];
         // Set has priority so a drop is never lost to a concurrent clear.
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // TX FSM: state register / next state / outputs
   tx_state_t        state;
   tx_state_t        state_next;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             txd_next;
   logic             bit_end;

   assign bit_end = (baud_cnt == '0);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
         STOP:    if (bit_end) state_next = fifo_empty ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = 1'b0;
      txd_next = 1'b1;
      case (state)
         IDLE:    fifo_pop = !fifo_empty;
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_reg[0];
         // Chaining straight into the next start bit avoids an idle gap.
         STOP:    fifo_pop = bit_end && !fifo_empty;
         default: fifo_pop = 1'b0;
      endcase
   end

   // Bit timing: the counter is preloaded while idle so each bit period,
   // including the first start bit, lasts exactly BAUD_DIV cycles.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         TXD      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         TXD <= txd_next;
         if (state == IDLE || bit_end) baud_cnt <= BAUD_LAST;
         else                          baud_cnt <= baud_cnt - CNT_W'(1);
         if (state != DATA) bit_idx <= '0;
         else if (bit_end)  bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_pop)                    shift_reg <= fifo_rdata;
      else if (state == DATA && bit_end) shift_reg <= {1'b0, shift_reg[7:1]};
   end

   // Read stage: registered mux, holds while IO_ren is low
   logic [31:0] status;
   logic [31:0] rd_mux;

   always_comb begin
      status                           = '0;
      status[ST_FULL]                  = fifo_full;
      status[ST_EMPTY]                 = fifo_empty;
      status[ST_BUSY]                  = (state != IDLE);
      status[ST_OVERFLOW]              = overflow;
      status[ST_LEVEL_MSB:ST_LEVEL_LSB] = 8'(fifo_level);
   end

   always_comb begin
      rd_mux = '0;
      if (sel_led)    rd_mux = 32'(LEDS);
      if (sel_status) rd_mux = status;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)       IO_rdata <= '0;
      else if (IO_ren) IO_rdata <= rd_mux;
   end

endmodule
